// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester round-robin arbiter in front of a registered data memory
// Every output is a flop; the memory port is driven directly from the transaction latches.
module dm_arbiter #(
   parameter int DW    = 16,
   parameter int ROW_D = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [15:0]   addr0,
   input  logic [15:0]   addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          err0,
   output logic          err1,
   output logic          busy,
   output logic [15:0]   mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_dw_or_dr,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   // 17 bits so ROW_D up to the full 64K word space still compares correctly
   localparam logic [16:0] ROW_LIM = 17'(ROW_D);

   state_t        r_state;
   logic          r_owner;
   logic          r_we;
   logic          r_oor;
   logic          r_last;
   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_err0;
   logic          r_err1;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          r_busy;
   logic [15:0]   r_mem_addr;
   logic [DW-1:0] r_mem_din;
   logic          r_mem_dw;

   logic          w_any;
   logic          w_win1;
   logic          w_we;
   logic [15:0]   w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_oor;
   logic [DW-1:0] w_capture;

   // r_last names the requester granted most recently; the other one wins a tie
   assign w_any     = req0 | req1;
   assign w_win1    = req1 & (~req0 | ~r_last);
   assign w_we      = w_win1 ? we1    : we0;
   assign w_addr    = w_win1 ? addr1  : addr0;
   assign w_wdata   = w_win1 ? wdata1 : wdata0;
   assign w_oor     = ({1'b0, w_addr} >= ROW_LIM);
   assign w_capture = r_oor ? '0 : mem_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_owner    <= 1'b0;
         r_we       <= 1'b0;
         r_oor      <= 1'b0;
         r_last     <= 1'b1;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_err0     <= 1'b0;
         r_err1     <= 1'b0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_busy     <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_mem_dw   <= 1'b0;
      end else begin
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner <= w_win1;
                  r_we    <= w_we;
                  r_oor   <= w_oor;
                  r_last  <= w_win1;
                  r_gnt0  <= ~w_win1;
                  r_gnt1  <= w_win1;
                  r_err0  <= ~w_win1 & w_oor;
                  r_err1  <= w_win1 & w_oor;
                  r_busy  <= 1'b1;
                  r_state <= S_ISSUE;
                  // an out-of-range access never reaches the memory port
                  if (!w_oor) begin
                     r_mem_addr <= w_addr;
                     r_mem_din  <= w_wdata;
                     r_mem_dw   <= w_we;
                  end
               end
            end
            S_ISSUE: begin
               r_mem_dw <= 1'b0;
               if (r_we) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (r_owner) begin
                  r_rdata1  <= w_capture;
                  r_rvalid1 <= 1'b1;
               end else begin
                  r_rdata0  <= w_capture;
                  r_rvalid0 <= 1'b1;
               end
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_mem_dw <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0         = r_gnt0;
   assign gnt1         = r_gnt1;
   assign err0         = r_err0;
   assign err1         = r_err1;
   assign rvalid0      = r_rvalid0;
   assign rvalid1      = r_rvalid1;
   assign rdata0       = r_rdata0;
   assign rdata1       = r_rdata1;
   assign busy         = r_busy;
   assign mem_addr     = r_mem_addr;
   assign mem_din      = r_mem_din;
   assign mem_dw_or_dr = r_mem_dw;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed and random-traffic bench for dm_arbiter
// Includes a registered 256-word memory model on the arbiter's memory port.
module tb_dm_arbiter;

   logic        clk;
   logic        rst;
   logic        t_req   [2];
   logic        t_we    [2];
   logic [15:0] t_addr  [2];
   logic [15:0] t_wd    [2];
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [1:0]  err;
   logic [15:0] rdata   [2];
   logic        busy;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_dw_or_dr;
   logic [15:0] mem_dout;
   logic [15:0] tmem    [256];

   int checks = 0;
   int errors = 0;

   dm_arbiter #(.DW(16), .ROW_D(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0         (t_req[0]),
      .req1         (t_req[1]),
      .we0          (t_we[0]),
      .we1          (t_we[1]),
      .addr0        (t_addr[0]),
      .addr1        (t_addr[1]),
      .wdata0       (t_wd[0]),
      .wdata1       (t_wd[1]),
      .gnt0         (gnt[0]),
      .gnt1         (gnt[1]),
      .rvalid0      (rvalid[0]),
      .rvalid1      (rvalid[1]),
      .rdata0       (rdata[0]),
      .rdata1       (rdata[1]),
      .err0         (err[0]),
      .err1         (err[1]),
      .busy         (busy),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dw_or_dr (mem_dw_or_dr),
      .mem_dout     (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_dw_or_dr) tmem[mem_addr[7:0]] <= mem_din;
      mem_dout <= tmem[mem_addr[7:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int n, input logic we, input logic [15:0] a, input logic [15:0] d);
      t_req[n]  = 1'b1;
      t_we[n]   = we;
      t_addr[n] = a;
      t_wd[n]   = d;
   endtask

   int unsigned wait_cnt [2];
   int          rd_cnt   [2];
   logic [15:0] exp_rd   [2];
   bit          exp_ok   [2];
   logic [15:0] shadow   [16];
   bit          sv       [16];

   initial begin
      rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         t_req[n] = 1'b0; t_we[n] = 1'b0; t_addr[n] = '0; t_wd[n] = '0;
      end
      tick();
      tick();
      chk("rst_gnt",    {30'b0, gnt},    0);
      chk("rst_rvalid", {30'b0, rvalid}, 0);
      chk("rst_err",    {30'b0, err},    0);
      chk("rst_busy",   busy,            0);
      chk("rst_mem_dw", mem_dw_or_dr,    0);
      chk("rst_mem_addr", mem_addr,      0);
      chk("rst_mem_din",  mem_din,       0);
      chk("rst_rdata0", rdata[0],        0);
      chk("rst_rdata1", rdata[1],        0);
      rst = 1'b0;

      // single write then read of addr 5
      set_req(0, 1'b1, 16'd5, 16'h1234);
      tick();
      chk("w_gnt",      {30'b0, gnt}, 2'b01);
      chk("w_busy",     busy, 1);
      chk("w_mem_dw",   mem_dw_or_dr, 1);
      chk("w_mem_addr", mem_addr, 16'd5);
      chk("w_mem_din",  mem_din, 16'h1234);
      chk("w_err",      {30'b0, err}, 0);
      t_req[0] = 1'b0;
      tick();
      chk("w_gnt_end",  {30'b0, gnt}, 0);
      chk("w_mem_dw_end", mem_dw_or_dr, 0);
      chk("w_busy_end", busy, 0);
      set_req(0, 1'b0, 16'd5, 16'h0);
      tick();
      chk("r_gnt",    {30'b0, gnt}, 2'b01);
      chk("r_mem_dw", mem_dw_or_dr, 0);
      t_req[0] = 1'b0;
      tick();
      chk("r_rvalid_e1", {30'b0, rvalid}, 0);
      chk("r_busy_e1",   busy, 1);
      tick();
      chk("r_rvalid",  {30'b0, rvalid}, 2'b01);
      chk("r_rdata0",  rdata[0], 16'h1234);
      chk("r_busy_e2", busy, 0);
      tick();
      chk("r_rvalid_pulse", {30'b0, rvalid}, 0);
      chk("r_rdata0_hold",  rdata[0], 16'h1234);

      // tie from reset, then a second tie
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 1'b0, 16'd5, 16'h0);
      set_req(1, 1'b0, 16'd5, 16'h0);
      tick();
      chk("tie_gnt_a", {30'b0, gnt}, 2'b01);
      t_req[0] = 1'b0;
      tick();
      chk("tie_wait1", {30'b0, gnt}, 0);
      tick();
      chk("tie_wait2", {30'b0, gnt}, 0);
      chk("tie_rvalid0", {30'b0, rvalid}, 2'b01);
      tick();
      chk("tie_gnt_b", {30'b0, gnt}, 2'b10);
      t_req[1] = 1'b0;
      tick();
      tick();
      chk("tie_rvalid1", {30'b0, rvalid}, 2'b10);
      chk("tie_rdata1",  rdata[1], 16'h1234);
      set_req(0, 1'b0, 16'd5, 16'h0);
      set_req(1, 1'b0, 16'd5, 16'h0);
      tick();
      chk("tie2_gnt", {30'b0, gnt}, 2'b01);
      t_req[0] = 1'b0;
      t_req[1] = 1'b0;
      tick(); tick(); tick();

      // back-to-back write then read from requester 1
      set_req(1, 1'b1, 16'd7, 16'h00FF);
      tick();
      chk("b2b_gnt_w", {30'b0, gnt}, 2'b10);
      set_req(1, 1'b0, 16'd7, 16'h0);
      tick();
      chk("b2b_gap", {30'b0, gnt}, 0);
      tick();
      chk("b2b_gnt_r", {30'b0, gnt}, 2'b10);
      t_req[1] = 1'b0;
      tick();
      tick();
      chk("b2b_rvalid", {30'b0, rvalid}, 2'b10);
      chk("b2b_rdata1", rdata[1], 16'h00FF);

      // out-of-range write and read
      set_req(0, 1'b1, 16'd300, 16'hBEEF);
      tick();
      chk("oor_w_gnt",  {30'b0, gnt}, 2'b01);
      chk("oor_w_err",  {30'b0, err}, 2'b01);
      chk("oor_w_dw",   mem_dw_or_dr, 0);
      chk("oor_w_addr_hold", mem_addr, 16'd7);
      t_req[0] = 1'b0;
      tick();
      chk("oor_w_dw2",  mem_dw_or_dr, 0);
      chk("oor_w_err2", {30'b0, err}, 0);
      set_req(0, 1'b0, 16'd300, 16'h0);
      tick();
      chk("oor_r_err", {30'b0, err}, 2'b01);
      t_req[0] = 1'b0;
      tick();
      tick();
      chk("oor_r_rvalid", {30'b0, rvalid}, 2'b01);
      chk("oor_r_rdata0", rdata[0], 0);

      // reset during ISSUE of a write
      set_req(0, 1'b1, 16'd9, 16'h1111);
      tick();
      t_req[0] = 1'b0;
      tick();
      set_req(0, 1'b1, 16'd9, 16'h2222);
      tick();
      chk("rmid_issue_dw", mem_dw_or_dr, 1);
      t_req[0] = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rmid_dw_async",  mem_dw_or_dr, 0);
      chk("rmid_busy",      busy, 0);
      tick();
      tick();
      rst = 1'b0;
      chk("rmid_mem9", tmem[9], 16'h1111);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rmid_quiet", {28'b0, gnt, rvalid}, 0);
      end
      set_req(0, 1'b0, 16'd9, 16'h0);
      tick();
      t_req[0] = 1'b0;
      tick();
      tick();
      chk("rmid_rdata0", rdata[0], 16'h1111);

      // random traffic
      for (int i = 0; i < 16; i++) sv[i] = 1'b0;
      for (int n = 0; n < 2; n++) begin
         wait_cnt[n] = 0; rd_cnt[n] = 0; exp_rd[n] = '0; exp_ok[n] = 1'b0;
      end
      for (int c = 0; c < 3000; c++) begin
         tick();
         chk("st_one_gnt",    {31'b0, gnt[0] & gnt[1]}, 0);
         chk("st_one_rvalid", {31'b0, rvalid[0] & rvalid[1]}, 0);
         for (int n = 0; n < 2; n++) begin
            if (rd_cnt[n] > 0) begin
               rd_cnt[n]--;
               if (rd_cnt[n] == 0) begin
                  chk("st_rvalid", rvalid[n], 1);
                  if (exp_ok[n]) chk("st_rdata", rdata[n], exp_rd[n]);
               end else begin
                  chk("st_rvalid_early", rvalid[n], 0);
               end
            end else begin
               chk("st_rvalid_idle", rvalid[n], 0);
            end
            if (gnt[n]) begin
               chk("st_gnt_req", t_req[n], 1);
               chk("st_starve", {31'b0, wait_cnt[n] <= 1}, 1);
               wait_cnt[n] = 0;
               if (t_we[n]) begin
                  shadow[t_addr[n][3:0]] = t_wd[n];
                  sv[t_addr[n][3:0]]     = 1'b1;
               end else begin
                  rd_cnt[n] = 2;
                  exp_rd[n] = shadow[t_addr[n][3:0]];
                  exp_ok[n] = sv[t_addr[n][3:0]];
               end
            end
         end
         for (int n = 0; n < 2; n++)
            if (gnt[1-n] && t_req[n] && !gnt[n]) wait_cnt[n]++;
         for (int n = 0; n < 2; n++) begin
            if (gnt[n] || !t_req[n]) begin
               if (c < 2990 && $urandom_range(0, 2) != 0) begin
                  set_req(n, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
                  wait_cnt[n] = 0;
               end else begin
                  t_req[n] = 1'b0;
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DW, default 16, data width; matches data memory word width.
REQ-002 Parameter ROW_D, default 256, number of valid data memory words; addresses >= ROW_D are out of range.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (display/keypad scanner).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0, addr1  input  16 each  word address.
REQ-008 wdata0, wdata1  input  DW each  write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse: read data valid on rdataN.
REQ-011 rdata0, rdata1  output  DW each  read data, held until the next rvalid for that requester.
REQ-012 err0, err1  output  1 each  one-cycle pulse, coincident with gntN, for an out-of-range address.
REQ-013 busy  output  1  high whenever FSM is not IDLE.
REQ-014 mem_addr  output  16  to memory write_addr.
REQ-015 mem_din  output  DW  to memory Din.
REQ-016 mem_dw_or_dr  output  1  to memory DW_or_DR; 1 = write, 0 = read.
REQ-017 mem_dout  input  DW  from memory Dout; the memory registers it, so it updates one edge after the address is sampled.

Function
REQ-018 All outputs shall be registered.
REQ-019 FSM states: IDLE, ISSUE, CAPTURE.
REQ-020 IDLE: if no req, stay; else select winner, latch owner/we/addr/wdata, pulse gntN, go ISSUE.
REQ-021 Arbitration: single req wins; both req -> requester not granted most recently wins (round-robin on a 1-bit last-grant pointer, updated on every grant).
REQ-022 In-range accept: mem_addr = addrN and mem_din = wdataN from the next cycle; mem_dw_or_dr = weN during the ISSUE cycle only.
REQ-023 ISSUE: memory samples at the closing edge; mem_dw_or_dr returns to 0 at that edge; write -> IDLE, read -> CAPTURE.
REQ-024 CAPTURE: at closing edge rdataN <= mem_dout, pulse rvalidN, go IDLE.
REQ-025 Latency, measured from the accept edge E0: gnt high in cycle E0..E1; a write commits at E1; a read gives rvalid high in cycle E2..E3.
REQ-026 Occupancy: a write occupies 2 cycles and a read 3 cycles, including the IDLE accept cycle.
REQ-027 Requests are sampled only in IDLE. A requester shall deassert req or present a new request no later than its gnt cycle; req high in a later IDLE cycle is a new request.
REQ-028 Out-of-range accept (addrN >= ROW_D): gntN and errN pulse; mem_dw_or_dr stays 0, so no write occurs.
REQ-029 Out-of-range read: rdataN <= 0 and rvalidN pulses at the same latency as a normal read.
REQ-030 mem_addr and mem_din shall hold their last value while idle; mem_dw_or_dr shall be 0 in every state except ISSUE of an in-range write.
REQ-031 At most one gnt, one rvalid and one err shall be high per cycle.

Reset
REQ-032 While rst is high: state = IDLE, mem_dw_or_dr = 0, mem_addr = 0, mem_din = 0, last-grant pointer = 1 (requester 0 wins the first tie).
REQ-033 While rst is high: all gnt, rvalid, err = 0; rdata0 = rdata1 = 0; busy = 0.
REQ-034 Reset asserted mid-transaction abandons it: no write commits after rst rises, and no rvalid is issued for it.

Verification
REQ-035 Single write: req0=1, we0=1, addr0=5, wdata0=16'h1234 -> gnt0 one cycle, mem_dw_or_dr=1 for exactly one cycle, busy high for 1 cycle; a later req0 read of addr 5 -> rvalid0 with rdata0=16'h1234 two cycles after gnt0.
REQ-036 Tie, then repeated tie: req0 and req1 both read from reset -> gnt0 first, gnt1 exactly 3 cycles later; a second tie -> gnt0 again (alternation preserved).
REQ-037 Back-to-back: req1 write addr 7 = 16'h00FF, then read addr 7 -> second gnt1 exactly 2 cycles after the first; rdata1=16'h00FF.
REQ-038 Out of range (ROW_D=256): req0 write addr 300 -> gnt0 and err0 same cycle, mem_dw_or_dr never 1; read addr 300 -> rdata0=0 with rvalid0.
REQ-039 Reset mid-op: rst asserted during ISSUE of a write to addr 9 -> mem_dw_or_dr=0 immediately; addr 9 keeps its old value; no gnt/rvalid until a new request after reset.
REQ-040 Stress: random req0/req1 traffic against a memory model -> every read matches the last write to that address; no cycle with two gnt or two rvalid; no requester starved beyond one competing transaction.
